anton_neopixel_decoder: RTL and testbench

- WS2812 line receiver: the decode-side counterpart of the NeoPixel stream transmitter, running in the same 7 MHz domain.
- Samples a NeoPixel data line and measures each high pulse to recover bits.
- Assembles bits MSB-first into bytes and hands them out over a valid/ready interface.
- Flags frame end on a reset-length low. Used for loopback self-test of the transmitter and for capturing external pixel streams.

---
 rtl/anton_neopixel_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_anton_neopixel_decoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_decoder.sv
// ---------------------------------------------------------------------------
// anton_neopixel_decoder
//
// WS2812 line receiver. Synchronizes the NeoPixel data line into the clk7mhz
// domain, measures every high pulse to recover one bit (wide = 1, narrow = 0),
// assembles bits MSB-first into bytes and hands them out on a valid/ready
// port. A reset-length low closes the frame with a one-cycle frameEnd pulse.
//
// Optional build macro: NEO_DECODER_GLITCH_FILTER_EN
//   When defined, the synchronized line only changes level once both
//   synchronizer stages agree, so single-tick spikes are ignored. Both edges
//   are delayed equally, so pulse widths are unchanged; output latency grows
//   by one clock.
//
// Ports:
//   clk7mhz    in   1           sole clock
//   reset      in   1           asynchronous active-high reset
//   neoIn      in   1           asynchronous NeoPixel data line
//   dataOut    out  8           decoded byte, meaningful while dataValid=1
//   dataValid  out  1           byte available, held until accepted
//   dataReady  in   1           consumer accepts on dataValid & dataReady
//   frameEnd   out  1           one-cycle pulse when a reset-length low ends
//   byteCount  out  COUNT_BITS  bytes decoded in the current or last frame
//   overrun    out  1           sticky: a completed byte was dropped
//   errPulse   out  1           one-cycle pulse on a protocol error
// ---------------------------------------------------------------------------
module anton_neopixel_decoder #(
    parameter int THRESHOLD    = 4,
    parameter int MAX_HIGH     = 7,
    parameter int RESET_DETECT = 350,
    parameter int COUNT_BITS   = 13
) (
    input  logic                  clk7mhz,
    input  logic                  reset,
    input  logic                  neoIn,
    output logic [7:0]            dataOut,
    output logic                  dataValid,
    input  logic                  dataReady,
    output logic                  frameEnd,
    output logic [COUNT_BITS-1:0] byteCount,
    output logic                  overrun,
    output logic                  errPulse
);

    localparam int LOW_W  = $clog2(RESET_DETECT + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH + 2);

    localparam logic [1:0] SYNC_WAIT = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] HIGH      = 2'd2;
    localparam logic [1:0] LOW       = 2'd3;

    logic                  sync1_r;
    logic                  sync2_r;
    logic                  line_s;
    logic [1:0]            state_r;
    logic [LOW_W-1:0]      low_cnt_r;
    logic [HIGH_W-1:0]     high_cnt_r;
    logic [2:0]            bit_cnt_r;
    logic [6:0]            shift_r;
    logic                  bit_s;
    logic [7:0]            byte_s;
    logic                  complete_s;
    logic                  drop_s;

    // Two-flop synchronizer for the asynchronous data line
    always_ff @(posedge clk7mhz or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= neoIn;
            sync2_r <= sync1_r;
        end
    end

`ifdef NEO_DECODER_GLITCH_FILTER_EN
    logic filt_r;

    // Follow the synchronizer only once its two stages agree on the new level
    always_ff @(posedge clk7mhz or posedge reset) begin
        if (reset) begin
            filt_r <= 1'b0;
        end else if (sync1_r == sync2_r) begin
            filt_r <= sync2_r;
        end else begin
            filt_r <= filt_r;
        end
    end

    assign line_s = filt_r;
`else
    assign line_s = sync2_r;
`endif

    // The bit being closed by a falling edge, and the byte it would complete
    assign bit_s      = (high_cnt_r >= HIGH_W'(THRESHOLD));
    assign byte_s     = {shift_r, bit_s};
    assign complete_s = (state_r == HIGH) && !line_s && (bit_cnt_r == 3'd7);
    assign drop_s     = complete_s && dataValid && !dataReady;

    // Pulse measurement, bit assembly and frame bookkeeping
    always_ff @(posedge clk7mhz or posedge reset) begin
        if (reset) begin
            state_r    <= SYNC_WAIT;
            low_cnt_r  <= '0;
            high_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 7'd0;
            byteCount  <= '0;
            overrun    <= 1'b0;
            frameEnd   <= 1'b0;
            errPulse   <= 1'b0;
        end else begin
            frameEnd <= 1'b0;
            errPulse <= 1'b0;
            case (state_r)
                // Refuse to decode until a full reset-length low has been seen,
                // so a receiver released mid-frame never emits garbage.
                SYNC_WAIT: begin
                    if (line_s) begin
                        low_cnt_r <= '0;
                    end else if (low_cnt_r == LOW_W'(RESET_DETECT - 1)) begin
                        low_cnt_r <= '0;
                        state_r   <= IDLE;
                    end else begin
                        low_cnt_r <= low_cnt_r + LOW_W'(1);
                    end
                end
                IDLE: begin
                    if (line_s) begin
                        state_r    <= HIGH;
                        high_cnt_r <= HIGH_W'(1);
                        bit_cnt_r  <= 3'd0;
                        byteCount  <= '0;
                        overrun    <= 1'b0;
                    end
                end
                HIGH: begin
                    if (line_s) begin
                        if (high_cnt_r >= HIGH_W'(MAX_HIGH)) begin
                            // Over-long pulse: lose the partial byte and resync
                            errPulse   <= 1'b1;
                            bit_cnt_r  <= 3'd0;
                            low_cnt_r  <= '0;
                            high_cnt_r <= HIGH_W'(MAX_HIGH + 1);
                            state_r    <= SYNC_WAIT;
                        end else begin
                            high_cnt_r <= high_cnt_r + HIGH_W'(1);
                        end
                    end else begin
                        shift_r   <= byte_s[6:0];
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        low_cnt_r <= LOW_W'(1);
                        state_r   <= LOW;
                        if (complete_s) begin
                            // Dropped bytes still count toward the frame length
                            if (byteCount != {COUNT_BITS{1'b1}}) begin
                                byteCount <= byteCount + COUNT_BITS'(1);
                            end
                            if (drop_s) begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                LOW: begin
                    if (line_s) begin
                        high_cnt_r <= HIGH_W'(1);
                        state_r    <= HIGH;
                    end else if (low_cnt_r == LOW_W'(RESET_DETECT - 1)) begin
                        // Frame closes; a half-assembled byte is a protocol error
                        frameEnd  <= 1'b1;
                        errPulse  <= (bit_cnt_r != 3'd0);
                        bit_cnt_r <= 3'd0;
                        low_cnt_r <= '0;
                        state_r   <= IDLE;
                    end else begin
                        low_cnt_r <= low_cnt_r + LOW_W'(1);
                    end
                end
                default: begin
                    state_r <= SYNC_WAIT;
                end
            endcase
        end
    end

    // Output holding register: a full, unaccepted register keeps its byte
    always_ff @(posedge clk7mhz or posedge reset) begin
        if (reset) begin
            dataOut   <= 8'd0;
            dataValid <= 1'b0;
        end else if (complete_s && !drop_s) begin
            dataOut   <= byte_s;
            dataValid <= 1'b1;
        end else if (dataValid && dataReady) begin
            dataValid <= 1'b0;
        end else begin
            dataValid <= dataValid;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
module tb_anton_neopixel_decoder;

    localparam int RD = 350;
`ifdef NEO_DECODER_GLITCH_FILTER_EN
    localparam bit FILTER = 1'b1;
    localparam int LAT    = 3;   // edges from first low-sampling edge to dataValid
`else
    localparam bit FILTER = 1'b0;
    localparam int LAT    = 2;
`endif

    logic        clk7mhz = 1'b0;
    logic        reset;
    logic        neoIn;
    logic        dataReady;
    logic [7:0]  dataOut;
    logic        dataValid;
    logic        frameEnd;
    logic [12:0] byteCount;
    logic        overrun;
    logic        errPulse;

    anton_neopixel_decoder dut (
        .clk7mhz  (clk7mhz),
        .reset    (reset),
        .neoIn    (neoIn),
        .dataOut  (dataOut),
        .dataValid(dataValid),
        .dataReady(dataReady),
        .frameEnd (frameEnd),
        .byteCount(byteCount),
        .overrun  (overrun),
        .errPulse (errPulse)
    );

    initial forever #5 clk7mhz = ~clk7mhz;

    int cyc = 0;
    always @(posedge clk7mhz) cyc <= cyc + 1;

    typedef struct {
        bit is_fe;
        bit err;
        int bc;
        bit ov;
    } evt_t;

    evt_t       evt_q[$];
    logic [7:0] byte_q[$];
    int         lat_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model (pulse level) -------------
    // m_state: 0 = waiting for a reset-length low, 1 = between frames, 2 = in frame
    int         m_state;
    int         m_lrun;
    int         m_nb;
    logic [7:0] m_sh;
    int         m_bc;
    bit         m_ov;
    bit         m_full;
    bit         m_rdy;

    task automatic mdl_reset();
        m_state = 0; m_lrun = 0; m_nb = 0; m_sh = 8'h00;
        m_bc = 0; m_ov = 1'b0; m_full = 1'b0;
    endtask

    task automatic mdl_low(input int n);
        evt_t e;
        m_lrun += n;
        if (m_lrun >= RD) begin
            if (m_state == 2) begin
                e.is_fe = 1'b1; e.err = (m_nb != 0); e.bc = m_bc; e.ov = m_ov;
                evt_q.push_back(e);
                m_nb = 0;
                m_state = 1;
            end else if (m_state == 0) begin
                m_state = 1;
            end
        end
    endtask

    // w = high width in ticks, e0 = edge index of the first low tick after it
    task automatic mdl_high(input int w, input int e0);
        evt_t e;
        if (FILTER && w == 1) begin
            mdl_low(1);
        end else begin
            m_lrun = 0;
            if (m_state == 1) begin
                m_state = 2; m_bc = 0; m_ov = 1'b0; m_nb = 0;
            end
            if (m_state == 2) begin
                if (w > 7) begin
                    e.is_fe = 1'b0; e.err = 1'b1; e.bc = 0; e.ov = 1'b0;
                    evt_q.push_back(e);
                    m_nb = 0;
                    m_state = 0;
                end else begin
                    m_sh = {m_sh[6:0], (w >= 4)};
                    m_nb++;
                    if (m_nb == 8) begin
                        m_nb = 0;
                        if (m_bc < 8191) m_bc++;
                        if (m_full) begin
                            m_ov = 1'b1;
                        end else begin
                            byte_q.push_back(m_sh);
                            lat_q.push_back(e0 + LAT);
                            m_full = !m_rdy;
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick(input bit v);
        neoIn = v;
        @(posedge clk7mhz);
        #1;
    endtask

    task automatic pulse(input int hw, input int lw);
        mdl_high(hw, cyc + hw + 1);
        mdl_low(lw);
        repeat (hw) tick(1'b1);
        repeat (lw) tick(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) pulse(5, 3);
            else      pulse(2, 6);
        end
    endtask

    // Low gap of n ticks; dataReady switches to rdy once any pending load has landed
    task automatic gap(input int n, input bit rdy);
        mdl_low(n);
        repeat (4) tick(1'b0);
        dataReady = rdy;
        m_rdy = rdy;
        if (rdy) m_full = 1'b0;
        repeat (n - 4) tick(1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_dataOut",   dataOut,   0);
        check("rst_dataValid", dataValid, 0);
        check("rst_frameEnd",  frameEnd,  0);
        check("rst_byteCount", byteCount, 0);
        check("rst_overrun",   overrun,   0);
        check("rst_errPulse",  errPulse,  0);
    endtask

    task automatic do_reset();
        check("idle_before_reset", evt_q.size() + byte_q.size() + lat_q.size(), 0);
        evt_q.delete(); byte_q.delete(); lat_q.delete();
        neoIn = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk7mhz);
        #1;
        reset = 1'b0;
        mdl_reset();
    endtask

    // ---------------- monitor / scoreboard -----------------------------------
    initial begin
        bit   prev_v;
        evt_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk7mhz);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (dataValid && !prev_v) begin
                    if (lat_q.size() == 0) check("spurious_valid", 1, 0);
                    else check("valid_latency", cyc, lat_q.pop_front());
                end
                if (dataValid && dataReady) begin
                    if (byte_q.size() == 0) check("spurious_byte", dataOut, 0);
                    else check("byte_value", dataOut, byte_q.pop_front());
                end
                if (frameEnd || errPulse) begin
                    if (evt_q.size() == 0) begin
                        check("spurious_event", {frameEnd, errPulse}, 0);
                    end else begin
                        e = evt_q.pop_front();
                        check("event_kind", frameEnd, e.is_fe);
                        check("event_err", errPulse, e.err);
                        if (frameEnd) begin
                            check("fe_byteCount", byteCount, e.bc);
                            check("fe_overrun",   overrun,   e.ov);
                        end
                    end
                end
                prev_v = dataValid;
            end
        end
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ------------------------------------------
    initial begin
        reset = 1'b1;
        neoIn = 1'b0;
        dataReady = 1'b0;
        m_rdy = 1'b0;
        mdl_reset();
        repeat (3) @(posedge clk7mhz);
        #1;
        check_reset_outputs();
        reset = 1'b0;

        // Single clean byte with the consumer ready
        gap(400, 1'b1);
        send_byte(8'hA5);
        gap(400, 1'b1);

        // Data straight after reset is ignored until a reset-length low
        do_reset();
        send_byte(8'hFF);
        gap(400, 1'b1);
        send_byte(8'h3C);
        gap(400, 1'b1);

        // Reset arriving in the middle of a byte (byteCount/dataOut non-zero before)
        send_byte(8'h96);
        for (int i = 0; i < 4; i++) pulse(5, 3);
        repeat (3) tick(1'b1);
        do_reset();
        gap(400, 1'b1);

        // Consumer stalled: first byte kept, the rest dropped and counted
        gap(20, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        gap(400, 1'b1);
        pulse(2, 6);
        check("ov_cleared_on_new_frame", overrun, m_ov);
        check("bc_cleared_on_new_frame", byteCount, m_bc);
        send_byte(8'h7F);
        gap(400, 1'b1);

        // Over-long pulse mid-byte, then data before a full resync is ignored
        for (int i = 0; i < 3; i++) pulse(5, 3);
        pulse(9, 3);
        gap(100, 1'b1);
        send_byte(8'hF0);
        gap(400, 1'b1);
        send_byte(8'h81);
        gap(400, 1'b1);

        // Partial byte at frame end
        for (int i = 0; i < 5; i++) pulse(5, 3);
        gap(400, 1'b1);

        // One-tick spike inside a low gap while sending 0x5A
        pulse(2, 6); pulse(5, 3); pulse(2, 6); pulse(5, 3);
        pulse(1, 3);
        pulse(5, 3); pulse(2, 6); pulse(5, 3); pulse(2, 6);
        gap(400, 1'b1);

        // Randomized frames: widths, gaps around the reset length, errors, spikes
        for (int f = 0; f < 14; f++) begin
            bit         rdy;
            int         nbytes;
            logic [7:0] val;
            rdy = 1'($urandom_range(0, 1));
            nbytes = $urandom_range(1, 4);
            gap($urandom_range(340, 420), rdy);
            for (int b = 0; b < nbytes; b++) begin
                val = 8'($urandom);
                for (int i = 7; i >= 0; i--) begin
                    if ($urandom_range(0, 59) == 0) pulse($urandom_range(8, 10), $urandom_range(2, 8));
                    if (val[i]) pulse($urandom_range(4, 7), $urandom_range(2, 8));
                    else        pulse($urandom_range(2, 3), $urandom_range(2, 8));
                    if ($urandom_range(0, 39) == 0) pulse(1, $urandom_range(2, 5));
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                for (int i = 0; i < 3; i++) pulse($urandom_range(2, 7), $urandom_range(2, 8));
            end
        end
        gap(400, 1'b1);
        repeat (10) tick(1'b0);

        check("bytes_all_seen",  byte_q.size(), 0);
        check("events_all_seen", evt_q.size(),  0);
        check("loads_all_seen",  lat_q.size(),  0);
        check("final_dataValid", dataValid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
